// File: rtl/priority_dec_20.sv
// priority_dec_20 -- two-stage pipelined leading-one decoder.
//
// Rebuilds a W-bit unsigned magnitude from a leading-one position code
// (position + 1, 0 = zero value) and the normalized mantissa bits that sit
// below the leading one. Codes above W are illegal: they produce a zero
// result with out_err set and bump a saturating error counter.
//
// Pipeline: S1 captures the beat and its shift amount, S2 captures the
// shifted (and optionally rounded) result. Both stages use valid/ready
// handshakes with full backpressure and no bubble on refill.
//
// Optional feature macro: PRIORITY_DEC_20_ROUND_EN
//   defined   -> discarded bits round to nearest, ties to even (applied in S2)
//   undefined -> discarded bits are truncated, no rounding logic is built
//
// Parameter constraint: 2**CW must exceed W so every legal code is encodable.

module priority_dec_20 #(
    parameter int W  = 20,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_code,
    input  logic [W-2:0]  in_mant,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_err,
    output logic [7:0]    err_cnt
);

    // Largest legal code, expressed at code width for width-clean compares.
    localparam logic [CW-1:0] W_CODE = CW'(W);

    // ------------------------------------------------------------------
    // Handshake signals
    // ------------------------------------------------------------------
    logic in_fire;
    logic s2_load;

    // ------------------------------------------------------------------
    // Stage 1 state: beat payload plus precomputed shift amount
    // ------------------------------------------------------------------
    logic          s1_valid_reg;
    logic [W-2:0]  s1_mant_reg;
    logic          s1_zero_reg;
    logic          s1_illegal_reg;
    logic [CW-1:0] s1_shamt_reg;

    logic          s1_zero_next;
    logic          s1_illegal_next;
    logic [CW-1:0] s1_shamt_next;

    // ------------------------------------------------------------------
    // Stage 2 state: final result, drives the outputs directly
    // ------------------------------------------------------------------
    logic         s2_valid_reg;
    logic [W-1:0] s2_data_reg;
    logic         s2_err_reg;

    logic [W-1:0] s2_data_next;

    // ------------------------------------------------------------------
    // Error counter
    // ------------------------------------------------------------------
    logic [7:0] err_cnt_reg;
    logic [7:0] err_cnt_next;

    // ------------------------------------------------------------------
    // Datapath between S1 and S2
    // ------------------------------------------------------------------
    logic [W-1:0] full_word;
    logic [W-1:0] shifted;
    logic         kill;
    logic         round_up;

    // S2 takes a new beat whenever it is empty or its beat leaves this cycle;
    // S1 may then accept because its contents move on at the same edge.
    always_comb begin
        s2_load  = s1_valid_reg && (!s2_valid_reg || out_ready);
        in_ready = !s1_valid_reg || s2_load;
        in_fire  = in_valid && in_ready;
    end

    // Classify the incoming code and derive the right-shift amount; zero and
    // illegal codes get a zero shift since their result is forced to 0 anyway.
    always_comb begin
        s1_zero_next    = (in_code == '0);
        s1_illegal_next = (in_code > W_CODE);
        s1_shamt_next   = '0;
        if (!s1_zero_next && !s1_illegal_next) begin
            s1_shamt_next = W_CODE - in_code;
        end
    end

    // S1 register: load on accept, drop validity when the beat moves to S2.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg   <= 1'b0;
            s1_mant_reg    <= '0;
            s1_zero_reg    <= 1'b0;
            s1_illegal_reg <= 1'b0;
            s1_shamt_reg   <= '0;
        end else begin
            if (in_fire) begin
                s1_valid_reg   <= 1'b1;
                s1_mant_reg    <= in_mant;
                s1_zero_reg    <= s1_zero_next;
                s1_illegal_reg <= s1_illegal_next;
                s1_shamt_reg   <= s1_shamt_next;
            end else if (s2_load) begin
                s1_valid_reg   <= 1'b0;
            end
        end
    end

    // Rebuild the full word with its implicit leading one and shift it down
    // so that the leading one lands at bit (code - 1).
    always_comb begin
        full_word = {1'b1, s1_mant_reg};
        shifted   = full_word >> s1_shamt_reg;
        kill      = s1_zero_reg || s1_illegal_reg;
    end

`ifdef PRIORITY_DEC_20_ROUND_EN
    // Per-bit selects over the discarded region: the guard bit is the highest
    // discarded bit (index shamt-1), sticky covers everything below it.
    logic [W-1:0] guard_sel;
    logic [W-1:0] sticky_mask;
    logic         guard_bit;
    logic         sticky_bit;

    for (genvar gi = 0; gi < W; gi++) begin : g_round_mask
        assign guard_sel[gi]   = (s1_shamt_reg == CW'(gi + 1));
        assign sticky_mask[gi] = (CW'(gi + 1) < s1_shamt_reg);
    end

    // Round to nearest, ties to even; a zero shift has no discarded bits so
    // code W never rounds, and forced-zero beats never round either.
    always_comb begin
        guard_bit  = |(full_word & guard_sel);
        sticky_bit = |(full_word & sticky_mask);
        round_up   = guard_bit && (sticky_bit || shifted[0]) && !kill;
    end
`else
    // Truncation: the discarded bits are simply dropped.
    always_comb begin
        round_up = 1'b0;
    end
`endif

    // Final result for S2. The increment cannot carry out of W bits: below
    // code W the shifted value is under 2**(W-1).
    always_comb begin
        s2_data_next = '0;
        if (!kill) begin
            s2_data_next = shifted + {{(W-1){1'b0}}, round_up};
        end
    end

    // S2 register: load from S1, otherwise hold until downstream takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
            s2_err_reg   <= 1'b0;
        end else begin
            if (s2_load) begin
                s2_valid_reg <= 1'b1;
                s2_data_reg  <= s2_data_next;
                s2_err_reg   <= s1_illegal_reg;
            end else if (out_ready) begin
                s2_valid_reg <= 1'b0;
            end
        end
    end

    // Count illegal codes as they are accepted, sticking at the top value.
    always_comb begin
        err_cnt_next = err_cnt_reg;
        if (in_fire && s1_illegal_next && (err_cnt_reg != 8'hFF)) begin
            err_cnt_next = err_cnt_reg + 8'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_reg <= '0;
        end else begin
            err_cnt_reg <= err_cnt_next;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        out_valid = s2_valid_reg;
        out_data  = s2_data_reg;
        out_err   = s2_err_reg;
        err_cnt   = err_cnt_reg;
    end

endmodule

// File: tb/tb_priority_dec_20.sv
// tb_priority_dec_20 -- directed self-checking bench for priority_dec_20.
// Expected values are hand-computed from the decode rule
// out = {1, mant} >> (20 - code).

module tb_priority_dec_20;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_code;
    logic [18:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_data;
    logic        out_err;
    logic [7:0]  err_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    priority_dec_20 #(.W(20), .CW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat through an otherwise idle pipeline, no backpressure.
    task automatic send_one(input string tag, input logic [4:0] code, input logic [18:0] mant,
                            input logic [19:0] exp_data, input logic exp_err);
        in_valid  = 1'b1;
        in_code   = code;
        in_mant   = mant;
        out_ready = 1'b1;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        check({tag, ".no_early_valid"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".data"}, 32'(out_data), 32'(exp_data));
        check({tag, ".err"}, 32'(out_err), 32'(exp_err));
        $display("beat %s code=%0d mant=%05h -> data=%05h err=%0b", tag, code, mant, out_data, out_err);
        tick();
    endtask

    logic [4:0]  sc [6];
    logic [18:0] sm [6];
    logic [19:0] se [6];
    logic [19:0] exp_tie;
    int          sent;
    int          got;
    logic        out_fire;
    logic        in_fire;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = '0;
        in_mant   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // Reset state
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_data",  32'(out_data),  32'd0);
        check("rst.out_err",   32'(out_err),   32'd0);
        check("rst.err_cnt",   32'(err_cnt),   32'd0);
        check("rst.in_ready",  32'(in_ready),  32'd1);

        // Single-beat decodes
        send_one("c20_ones", 5'd20, 19'h7FFFF, 20'hFFFFF, 1'b0);
        send_one("c1",       5'd1,  19'h3FFFF, 20'h00001, 1'b0);
        send_one("c0_ones",  5'd0,  19'h7FFFF, 20'h00000, 1'b0);
        send_one("c5",       5'd5,  19'h50000, 20'h0001A, 1'b0);
`ifdef PRIORITY_DEC_20_ROUND_EN
        exp_tie = 20'h0000C;
`else
        exp_tie = 20'h0000B;
`endif
        send_one("c4_tie",   5'd4,  19'h38000, exp_tie, 1'b0);
        send_one("c12",      5'd12, 19'h15555, 20'h00955, 1'b0);
        check("c12.err_cnt_zero", 32'(err_cnt), 32'd0);

        // Illegal code
        send_one("c25_illegal", 5'd25, 19'h12345, 20'h00000, 1'b1);
        check("c25.err_cnt", 32'(err_cnt), 32'd1);

        // 300 back-to-back illegal codes saturate the counter
        in_valid  = 1'b1;
        in_code   = 5'd31;
        in_mant   = 19'h7FFFF;
        out_ready = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 253) check("sat.err_cnt_254", 32'(err_cnt), 32'd254);
        end
        in_valid = 1'b0;
        tick();
        check("sat.err_cnt_255", 32'(err_cnt), 32'd255);
        check("sat.out_err", 32'(out_err), 32'd1);
        $display("illegal burst done err_cnt=%0d", err_cnt);
        repeat (3) tick();
        check("sat.drained", 32'(out_valid), 32'd0);

        // Backpressure stream: out_ready low for cycles 2..6
        sc[0] = 5'd20; sm[0] = 19'h12345; se[0] = 20'h92345;
        sc[1] = 5'd1;  sm[1] = 19'h00000; se[1] = 20'h00001;
        sc[2] = 5'd8;  sm[2] = 19'h00000; se[2] = 20'h00080;
        sc[3] = 5'd12; sm[3] = 19'h15555; se[3] = 20'h00955;
        sc[4] = 5'd0;  sm[4] = 19'h7FFFF; se[4] = 20'h00000;
        sc[5] = 5'd16; sm[5] = 19'h7FFF0; se[5] = 20'h0FFFF;
        sent = 0;
        got  = 0;
        for (int t = 0; t < 40 && got < 6; t++) begin
            in_valid = (sent < 6);
            if (sent < 6) begin
                in_code = sc[sent];
                in_mant = sm[sent];
            end
            out_ready = !(t >= 2 && t <= 6);
            #1;
            if (t == 2) begin
                check("bp.in_ready_low", 32'(in_ready), 32'd0);
                check("bp.held_valid", 32'(out_valid), 32'd1);
            end
            if (t == 5) check("bp.hold_data", 32'(out_data), 32'(se[0]));
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (out_fire) begin
                check($sformatf("bp.beat%0d", got), 32'(out_data), 32'(se[got]));
                check($sformatf("bp.err%0d", got), 32'(out_err), 32'd0);
                $display("stream beat %0d data=%05h", got, out_data);
                got++;
            end
            if (in_fire) sent++;
            tick();
        end
        in_valid = 1'b0;
        check("bp.count", 32'(got), 32'd6);

        // Reset in the middle of a stalled stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 5'd20;
        in_mant   = 19'h00001;
        repeat (3) tick();
        check("mid.before_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        check("mid.out_valid", 32'(out_valid), 32'd0);
        check("mid.err_cnt",   32'(err_cnt),   32'd0);
        check("mid.in_ready",  32'(in_ready),  32'd1);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("mid.flushed1", 32'(out_valid), 32'd0);
        tick();
        check("mid.flushed2", 32'(out_valid), 32'd0);
        $display("mid-stream reset done");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
